// File: rtl/snail_pattern_serializer.sv
// Serializes a captured W-bit pattern one bit per DIV clocks, with an en strobe marking each bit.
// Build option SNAIL_SER_LSB_FIRST_EN: shift right and present shreg[0] (LSB first); default is MSB first.
module snail_pattern_serializer #(
  parameter int W   = 8,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] pattern,
  input  logic         repeat_mode,
  output logic         en,
  output logic         a,
  output logic         busy,
  output logic         done
);

  // state    | meaning
  // IDLE     | waiting for load; outputs quiet
  // SHIFT    | presenting bits, one en strobe every DIV clocks
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam int CNT_W = $clog2(DIV + 1);
  localparam int BC_W  = $clog2(W);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(W - 1);

  state_t           state, state_nxt;
  logic [W-1:0]     shreg, shreg_nxt;
  logic [W-1:0]     copy, copy_nxt;
  logic [BC_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [CNT_W-1:0] div_cnt, div_cnt_nxt;
  logic             done_nxt;

  // Outputs decode registers only, so en and a never glitch.
  assign en   = (state == SHIFT) && (div_cnt == DIV_LAST);
  assign busy = (state == SHIFT);
`ifdef SNAIL_SER_LSB_FIRST_EN
  assign a    = (state == SHIFT) ? shreg[0] : 1'b0;
`else
  assign a    = (state == SHIFT) ? shreg[W-1] : 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    copy_nxt    = copy;
    bit_cnt_nxt = bit_cnt;
    div_cnt_nxt = div_cnt;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          copy_nxt    = pattern;
          shreg_nxt   = pattern;
          bit_cnt_nxt = BIT_LAST;
          div_cnt_nxt = '0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        div_cnt_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + CNT_W'(1);
        if (en) begin
          if (bit_cnt != '0) begin
`ifdef SNAIL_SER_LSB_FIRST_EN
            shreg_nxt = shreg >> 1;
`else
            shreg_nxt = shreg << 1;
`endif
            bit_cnt_nxt = bit_cnt - BC_W'(1);
          end else if (repeat_mode) begin
            // Reload from the captured copy so a live pattern change never leaks in.
            shreg_nxt   = copy;
            bit_cnt_nxt = BIT_LAST;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      copy    <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      copy    <= copy_nxt;
      bit_cnt <= bit_cnt_nxt;
      div_cnt <= div_cnt_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_snail_pattern_serializer.sv
// Scoreboard bench for snail_pattern_serializer: instance 0 uses DIV=4, instance 1 uses DIV=1.
// Expected (bit, cycle) pairs come from the pattern and load timing; a negedge monitor pops them.
module tb_snail_pattern_serializer;
  localparam int W = 8;

  typedef struct {
    logic a;
    int   cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   load_s = '0;
  logic [1:0]   rep_s = '0;
  logic [W-1:0] pat_s [2];
  logic [1:0]   en_s, a_s, busy_s, done_s;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  exp_t         exp_q [2][$];
  int           done_q [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    snail_pattern_serializer #(.W(W), .DIV(g == 0 ? 4 : 1)) u_dut (
      .clk(clk), .rst(rst), .load(load_s[g]), .pattern(pat_s[g]),
      .repeat_mode(rep_s[g]), .en(en_s[g]), .a(a_s[g]), .busy(busy_s[g]), .done(done_s[g])
    );
  end

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Bit sent at position j of a pass, straight from the configured bit order.
  function automatic logic bit_at(input logic [W-1:0] p, input int j);
`ifdef SNAIL_SER_LSB_FIRST_EN
    return p[j];
`else
    return p[W-1-j];
`endif
  endfunction

  task automatic check(input string nm, input int idx, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s[%0d] actual=%0d required=%0d (t=%0t)", nm, idx, act, req, $time);
    end
  endtask

  // Pass starting k0 bits after the accept edge T; bit k lands in cycle T+(k+1)*DIV-1.
  task automatic push_pass(input int i, input logic [W-1:0] p, input int t, input int k0);
    exp_t e;
    for (int j = 0; j < W; j++) begin
      e.a   = bit_at(p, j);
      e.cyc = t + (k0 + j + 1) * div_of(i) - 1;
      exp_q[i].push_back(e);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of the first SHIFT cycle.
  task automatic do_load(input int i, input logic [W-1:0] p, input logic r, output int t);
    load_s[i] = 1'b1;
    pat_s[i]  = p;
    rep_s[i]  = r;
    t = cyc + 1;
    push_pass(i, p, t, 0);
    if (!r) done_q[i].push_back(t + W * div_of(i));
    @(negedge clk);
    load_s[i] = 1'b0;
  endtask

  task automatic stray_load(input int i, input logic [W-1:0] p);
    load_s[i] = 1'b1;
    pat_s[i]  = p;
    @(negedge clk);
    load_s[i] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (en_s[i]) begin
          if (exp_q[i].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_en[%0d] actual=1 required=0 at cyc=%0d", i, cyc);
          end else begin
            exp_t e;
            e = exp_q[i].pop_front();
            check("a_at_en", i, int'(a_s[i]), int'(e.a));
            check("en_cycle", i, cyc, e.cyc);
            check("busy_at_en", i, int'(busy_s[i]), 1);
          end
        end
        if (done_s[i]) begin
          if (done_q[i].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done[%0d] actual=1 required=0 at cyc=%0d", i, cyc);
          end else begin
            check("done_cycle", i, cyc, done_q[i].pop_front());
            check("busy_at_done", i, int'(busy_s[i]), 0);
            check("en_at_done", i, int'(en_s[i]), 0);
          end
        end
      end
    end
  end

  initial begin
    int t, t2, d, tgt;
    logic [W-1:0] p;
    logic r;
    pat_s[0] = '0;
    pat_s[1] = '0;
    #12;
    for (int i = 0; i < 2; i++) begin
      check("rst_en", i, int'(en_s[i]), 0);
      check("rst_a", i, int'(a_s[i]), 0);
      check("rst_busy", i, int'(busy_s[i]), 0);
      check("rst_done", i, int'(done_s[i]), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Basic MSB-first pass.
    do_load(0, 8'b0110_1100, 1'b0, t);
    wait_until(t + W * 4 + 3);

    // Load mid-pass must be ignored.
    do_load(0, 8'hFF, 1'b0, t);
    wait_until(t + 10);
    stray_load(0, 8'h00);
    wait_until(t + W * 4 + 3);

    // Repeat for three passes, drop repeat during the third.
    do_load(0, 8'hA5, 1'b1, t);
    push_pass(0, 8'hA5, t, W);
    push_pass(0, 8'hA5, t, 2 * W);
    done_q[0].push_back(t + 3 * W * 4);
    wait_until(t + 2 * W * 4 + 5);
    rep_s[0] = 1'b0;
    wait_until(t + 3 * W * 4 + 3);

    // Async reset mid-shift, after the third bit.
    do_load(0, 8'h3C, 1'b0, t);
    wait_until(t + 12);
    #2 rst = 1'b1;
    #1;
    check("midrst_en", 0, int'(en_s[0]), 0);
    check("midrst_a", 0, int'(a_s[0]), 0);
    check("midrst_busy", 0, int'(busy_s[0]), 0);
    check("midrst_done", 0, int'(done_s[0]), 0);
    exp_q[0].delete();
    done_q[0].delete();
    #1 rst = 1'b0;
    @(negedge clk);
    do_load(0, 8'hC3, 1'b0, t);
    wait_until(t + W * 4 + 3);

    // Load held high: second pass accepted in the first IDLE cycle after done.
    load_s[0] = 1'b1;
    pat_s[0]  = 8'h96;
    rep_s[0]  = 1'b0;
    t  = cyc + 1;
    t2 = t + W * 4 + 1;
    push_pass(0, 8'h96, t, 0);
    done_q[0].push_back(t + W * 4);
    push_pass(0, 8'h96, t2, 0);
    done_q[0].push_back(t2 + W * 4);
    wait_until(t2 + 1);
    load_s[0] = 1'b0;
    wait_until(t2 + W * 4 + 3);

    // DIV=1: en every SHIFT cycle.
    do_load(1, 8'h81, 1'b0, t);
    wait_until(t + W + 3);

    // Randomized passes on both instances.
    for (int it = 0; it < 16; it++) begin
      int i;
      i = it % 2;
      d = div_of(i);
      p = W'($urandom);
      r = ($urandom_range(0, 2) == 0);
      do_load(i, p, r, t);
      if (r) begin
        push_pass(i, p, t, W);
        done_q[i].push_back(t + 2 * W * d);
        tgt = t + W * d + $urandom_range(0, W * d - 1);
        wait_until(tgt);
        rep_s[i] = 1'b0;
        wait_until(t + 2 * W * d + 2);
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          wait_until(t + $urandom_range(1, W * d - 1));
          stray_load(i, W'($urandom));
        end
        wait_until(t + W * d + 2);
      end
    end

    wait_until(cyc + 5);
    for (int i = 0; i < 2; i++) begin
      check("exp_q_drained", i, exp_q[i].size(), 0);
      check("done_q_drained", i, done_q[i].size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
